// File: rtl/lut_loader_if.sv
// lut_loader_if: coefficient stream and lookup port bundle for lut_loader
interface lut_loader_if #(
    parameter int size = 2,
    parameter int W = 16
);
    localparam int OW = W + $clog2(size) + 1;

    logic signed [W-1:0] coef_in;
    logic coef_valid;
    logic coef_ready;
    logic lut_ready;
    logic [size-1:0] sel;
    logic sel_valid;
    logic signed [OW-1:0] result;
    logic result_valid;

    modport master (
        output coef_in, coef_valid, sel, sel_valid,
        input coef_ready, lut_ready, result, result_valid
    );

    modport slave (
        input coef_in, coef_valid, sel, sel_valid,
        output coef_ready, lut_ready, result, result_valid
    );
endinterface

// File: rtl/lut_loader.sv
// lut_loader: runtime-loadable control-bit LUT built in Gray-code order; LUT_REGOUT_EN adds an output register stage
module lut_loader #(
    parameter int size = 2,
    parameter int W = 16
) (
    input logic clk,
    input logic rstn,
    lut_loader_if.slave bus
);
    localparam int OW = W + $clog2(size) + 1;
    localparam int KW = size > 1 ? $clog2(size) : 1;
    localparam int D = 2 ** size;
    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] BUILD = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    logic [1:0] state;
    logic [KW-1:0] k;
    logic [KW-1:0] j;
    logic [size-1:0] g;
    logic [size-1:0] gray;
    logic signed [OW-1:0] base;
    logic signed [OW-1:0] acc;
    logic signed [OW-1:0] nacc;
    logic signed [OW-1:0] delta;
    logic signed [OW-1:0] rd;
    logic signed [W-1:0] fact [size];
    logic signed [OW-1:0] mem [D];
    logic hit;

    function automatic logic signed [OW-1:0] sx(input logic signed [W-1:0] v);
        return {{(OW-W){v[W-1]}}, v};
    endfunction

    assign bus.coef_ready = state != BUILD;
    assign bus.lut_ready = state == READY;
    assign gray = g ^ (g >> 1);
    assign rd = mem[bus.sel];
    assign hit = bus.sel_valid && bus.lut_ready;

    // lowest set bit of the step counter names the single coefficient whose sign flips
    always_comb begin
        j = '0;
        for (int i = size - 1; i >= 0; i--) if (g[i]) j = KW'(i);
        delta = sx(fact[j]) <<< 1;
        nacc = gray[j] ? acc + delta : acc - delta;
    end

    // load / build / ready sequencing and coefficient capture
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= LOAD;
            k <= '0;
            g <= '0;
            base <= '0;
            acc <= '0;
            for (int i = 0; i < size; i++) fact[i] <= '0;
        end else begin
            case (state)
                LOAD: if (bus.coef_valid) begin
                    fact[k] <= bus.coef_in;
                    base <= base - sx(bus.coef_in);
                    k <= k + 1'b1;
                    if (k == KW'(size - 1)) begin
                        state <= BUILD;
                        k <= '0;
                        g <= '0;
                    end
                end
                BUILD: begin
                    acc <= g == '0 ? base : nacc;
                    g <= g + 1'b1;
                    if (&g) state <= READY;
                end
                default: if (bus.coef_valid) begin
                    fact[0] <= bus.coef_in;
                    base <= -sx(bus.coef_in);
                    k <= size == 1 ? '0 : KW'(1);
                    g <= '0;
                    state <= size == 1 ? BUILD : LOAD;
                end
            endcase
        end
    end

    // one table entry per build step, addressed by the Gray code of the step
    always_ff @(posedge clk) begin
        if (state == BUILD) mem[gray] <= g == '0 ? base : nacc;
    end

`ifdef LUT_REGOUT_EN
    logic signed [OW-1:0] r1;
    logic v1;

    // table read stage followed by an output register; each holds when idle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r1 <= '0;
            v1 <= 1'b0;
            bus.result <= '0;
            bus.result_valid <= 1'b0;
        end else begin
            v1 <= hit;
            if (hit) r1 <= rd;
            bus.result_valid <= v1;
            if (v1) bus.result <= r1;
        end
    end
`else
    // single-cycle lookup; result holds its last value when no request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.result <= '0;
            bus.result_valid <= 1'b0;
        end else begin
            bus.result_valid <= hit;
            if (hit) bus.result <= rd;
        end
    end
`endif
endmodule

// File: tb/tb_lut_loader.sv
// tb_lut_loader: directed checks of load, build, lookup, reload, extremes and reset for lut_loader
module tb_lut_loader;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n = 0;
    int nf = 0;

`ifdef LUT_REGOUT_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    always #5 clk = ~clk;

    lut_loader_if #(.size(2), .W(8)) bus ();
    lut_loader #(.size(2), .W(8)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] o, input logic signed [31:0] e);
        n++;
        assert (o === e) else begin
            nf++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic load(input int a, input int b);
        bus.coef_valid = 1'b1;
        bus.coef_in = 8'(a);
        step();
        bus.coef_in = 8'(b);
        step();
        bus.coef_valid = 1'b0;
    endtask

    task automatic build();
        repeat (3) begin
            step();
            chk("build_lut_ready", bus.lut_ready, 0);
        end
        step();
        chk("lut_ready_rise", bus.lut_ready, 1);
    endtask

    task automatic look(input logic [1:0] s, input int e);
        bus.sel = s;
        bus.sel_valid = 1'b1;
        step();
        bus.sel_valid = 1'b0;
        if (L == 2) step();
        chk("result", bus.result, e);
        chk("result_valid", bus.result_valid, 1);
    endtask

    initial begin
        bus.coef_in = '0;
        bus.coef_valid = 1'b0;
        bus.sel = '0;
        bus.sel_valid = 1'b0;
        repeat (2) step();
        chk("rst_coef_ready", bus.coef_ready, 1);
        chk("rst_lut_ready", bus.lut_ready, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_result_valid", bus.result_valid, 0);
        rstn = 1'b1;
        step();
        bus.sel_valid = 1'b1;
        step();
        bus.sel_valid = 1'b0;
        chk("load_lookup_dropped", bus.result_valid, 0);

        load(3, 5);
        build();
        look(2'd0, -8);
        look(2'd1, -2);
        look(2'd2, 2);
        look(2'd3, 8);
        step();
        chk("idle_result_valid", bus.result_valid, 0);
        chk("idle_result_hold", bus.result, 8);

        bus.coef_valid = 1'b1;
        bus.coef_in = 8'sd1;
        step();
        bus.coef_in = 8'sd2;
        step();
        bus.coef_in = 8'sd7;
        chk("bp_coef_ready", bus.coef_ready, 0);
        repeat (3) begin
            step();
            chk("bp_coef_ready", bus.coef_ready, 0);
            chk("bp_lut_ready", bus.lut_ready, 0);
        end
        step();
        chk("bp_ready_lut", bus.lut_ready, 1);
        chk("bp_ready_coef", bus.coef_ready, 1);
        bus.sel = 2'd3;
        bus.sel_valid = 1'b1;
        step();
        bus.sel_valid = 1'b0;
        bus.coef_valid = 1'b0;
        chk("reload_lut_drop", bus.lut_ready, 0);
        if (L == 2) step();
        chk("old_table_result", bus.result, 3);
        chk("old_table_valid", bus.result_valid, 1);

        bus.coef_valid = 1'b1;
        bus.coef_in = -8'sd4;
        step();
        bus.coef_valid = 1'b0;
        build();
        look(2'd0, -3);
        look(2'd1, 11);
        look(2'd2, -11);
        look(2'd3, 3);

        load(-128, -128);
        build();
        look(2'd0, 256);
        look(2'd3, -256);
        look(2'd1, 0);

        load(1, 2);
        repeat (2) step();
        rstn = 1'b0;
        #1;
        chk("arst_lut_ready", bus.lut_ready, 0);
        chk("arst_result_valid", bus.result_valid, 0);
        chk("arst_coef_ready", bus.coef_ready, 1);
        step();
        rstn = 1'b1;
        bus.sel = 2'd0;
        bus.sel_valid = 1'b1;
        repeat (6) begin
            step();
            chk("post_rst_dropped", bus.result_valid, 0);
        end
        bus.sel_valid = 1'b0;
        load(3, 5);
        build();
        look(2'd2, 2);
        look(2'd0, -8);

        $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
        $finish;
    end
endmodule
